// File: rtl/vector_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vector_sweep_ctrl_pkg
// Description : Shared types, defaults and helpers for the vector sweep block.
// Revision    : 1.0 - initial release
// ============================================================================
package vector_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRST   = 3'd1,
        SETTLE = 3'd2,
        EMIT   = 3'd3,
        FIN    = 3'd4
    } sweep_state_t;

    localparam int c_DEF_N_IN       = 7;
    localparam int c_DEF_N_OUT      = 1;
    localparam int c_DEF_SETTLE_CYC = 1;
    localparam int c_DEF_RESET_CYC  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : vector_sweep_ctrl_if
// Description : Control, DUT-drive and record-stream signals of the sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
interface vector_sweep_ctrl_if #(
    parameter int N_IN  = 7,
    parameter int N_OUT = 1
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             dut_rst;
    logic [N_IN-1:0]  dut_in;
    logic [N_OUT-1:0] dut_out;
    logic             rec_valid;
    logic             rec_ready;
    logic [N_IN-1:0]  rec_vec;
    logic [N_OUT-1:0] rec_out;
    logic             rec_last;

    modport master (
        input  start, abort, dut_out, rec_ready,
        output busy, done, dut_rst, dut_in, rec_valid, rec_vec, rec_out, rec_last
    );

    modport slave (
        output start, abort, dut_out, rec_ready,
        input  busy, done, dut_rst, dut_in, rec_valid, rec_vec, rec_out, rec_last
    );
endinterface
`default_nettype wire

// File: rtl/vector_sweep_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module      : vector_sweep_ctrl_timer
// Description : Loadable down-counter with zero flag; parks at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_sweep_ctrl_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/vector_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vector_sweep_ctrl
// Description : Sweeps every input vector into a DUT and streams {vec, out}.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_sweep_ctrl
    import vector_sweep_ctrl_pkg::*;
#(
    parameter int N_IN       = c_DEF_N_IN,
    parameter int N_OUT      = c_DEF_N_OUT,
    parameter int SETTLE_CYC = c_DEF_SETTLE_CYC,
    parameter int RESET_CYC  = c_DEF_RESET_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    vector_sweep_ctrl_if.master bus
);

    localparam logic [2:0] c_ST_IDLE   = IDLE;
    localparam logic [2:0] c_ST_DRST   = DRST;
    localparam logic [2:0] c_ST_SETTLE = SETTLE;
    localparam logic [2:0] c_ST_EMIT   = EMIT;
    localparam logic [2:0] c_ST_FIN    = FIN;

    localparam int               c_TMR_W    = $clog2(max_int(RESET_CYC, SETTLE_CYC)) + 1;
    localparam logic [c_TMR_W-1:0] c_RST_LOAD = c_TMR_W'(RESET_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_SET_LOAD = c_TMR_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]  c_VEC_LAST = '1;

    logic [2:0]         r_state;
    logic [N_IN-1:0]    r_vec;
    logic [N_IN-1:0]    r_rec_vec;
    logic [N_OUT-1:0]   r_rec_out;
    logic               w_tmr_load;
    logic [c_TMR_W-1:0] w_tmr_val;
    logic               w_tmr_zero;
    logic               w_is_last;
    logic               w_hs;

    // Last-vector detection is an explicit compare so the counter never wraps to 0.
    assign w_is_last = (r_vec == c_VEC_LAST);
    assign w_hs      = (r_state == c_ST_EMIT) && bus.rec_ready;

    // The timer is reloaded on every entry into DRST or SETTLE.
    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = c_SET_LOAD;
        case (r_state)
            c_ST_IDLE: begin
                w_tmr_load = bus.start;
                w_tmr_val  = c_RST_LOAD;
            end
            c_ST_DRST: w_tmr_load = w_tmr_zero;
            c_ST_EMIT: w_tmr_load = w_hs && !w_is_last;
            default:   w_tmr_load = 1'b0;
        endcase
    end

    vector_sweep_ctrl_timer #(
        .W (c_TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_vec     <= '0;
            r_rec_vec <= '0;
            r_rec_out <= '0;
        end else if (bus.abort) begin
            // A record handshaking on this edge is treated as undelivered.
            r_state <= c_ST_IDLE;
            r_vec   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= c_ST_DRST;
                        r_vec   <= '0;
                    end
                end
                c_ST_DRST: begin
                    if (w_tmr_zero) begin
                        r_state <= c_ST_SETTLE;
                    end
                end
                c_ST_SETTLE: begin
                    if (w_tmr_zero) begin
                        r_state   <= c_ST_EMIT;
                        r_rec_vec <= r_vec;
                        r_rec_out <= bus.dut_out;
                    end
                end
                c_ST_EMIT: begin
                    if (bus.rec_ready) begin
                        if (w_is_last) begin
                            r_state <= c_ST_FIN;
                        end else begin
                            r_state <= c_ST_SETTLE;
                            r_vec   <= r_vec + N_IN'(1);
                        end
                    end
                end
                c_ST_FIN:  r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state != c_ST_IDLE);
    assign bus.done      = (r_state == c_ST_FIN);
    assign bus.dut_rst   = (r_state == c_ST_DRST);
    assign bus.dut_in    = r_vec;
    assign bus.rec_valid = (r_state == c_ST_EMIT);
    assign bus.rec_vec   = r_rec_vec;
    assign bus.rec_out   = r_rec_out;
    assign bus.rec_last  = (r_state == c_ST_EMIT) && (r_rec_vec == c_VEC_LAST);

endmodule
`default_nettype wire

// File: tb/tb_vector_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_sweep_ctrl
// Description : Directed self-checking bench for vector_sweep_ctrl (parity DUT).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_sweep_ctrl;

    localparam int N_IN  = 7;
    localparam int N_OUT = 1;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    vector_sweep_ctrl_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

    vector_sweep_ctrl #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .SETTLE_CYC (1),
        .RESET_CYC  (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.dut_out = ^bus.dut_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One sweep with an ideal sink, optional stall, abort and start activity.
    task automatic sweep(input int stall_vec, input int abort_vec, input int glitch_vec,
                         input bit hold_start, input int exp_hs, input int exp_rec,
                         input int exp_done);
        int cyc, stall, exp_vec, hs_cyc, first_v, n_drst, n_rec, n_done;
        bit fin;
        logic [N_IN-1:0] ev;
        cyc = 0; stall = 0; exp_vec = 0; hs_cyc = -1; first_v = -1;
        n_drst = 0; n_rec = 0; n_done = 0; fin = 1'b0;
        bus.start     = 1'b1;
        bus.rec_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = hold_start;
        while (!fin) begin
            if (bus.done) n_done++;
            if (bus.dut_rst && n_rec == 0) n_drst++;
            if (hs_cyc >= 0 && cyc == hs_cyc) check_val("done_cyc", bus.done, 1);
            if (hs_cyc >= 0 && hold_start) begin
                if (cyc == hs_cyc + 1) check_val("fin_busy_gap", bus.busy, 0);
                if (cyc == hs_cyc + 2 || cyc == hs_cyc + 3) check_val("restart_drst", bus.dut_rst, 1);
                if (cyc == hs_cyc + 4) check_val("restart_drst_end", bus.dut_rst, 0);
            end
            if (!bus.rec_valid) check_val("last_idle", bus.rec_last, 0);
            if (bus.rec_valid && hs_cyc < 0) begin
                ev = exp_vec[N_IN-1:0];
                if (first_v < 0) begin
                    first_v = cyc;
                    check_val("first_valid_cyc", cyc, 3);
                end
                if (exp_vec == stall_vec && stall < 5) begin
                    bus.rec_ready = 1'b0;
                    stall++;
                    check_val("stall_rec", {bus.rec_vec, bus.rec_out, bus.dut_in}, {ev, ^ev, ev});
                end else begin
                    bus.rec_ready = 1'b1;
                    check_val("rec", {bus.rec_vec, bus.rec_out, bus.rec_last},
                              {ev, ^ev, (exp_vec == 127)});
                    if (exp_vec == abort_vec) begin
                        bus.abort = 1'b1;
                        @(posedge clk);
                        @(negedge clk);
                        bus.abort = 1'b0;
                        check_val("abort_outs", {bus.busy, bus.rec_valid, bus.dut_rst, bus.dut_in}, 0);
                        repeat (5) begin
                            @(posedge clk);
                            @(negedge clk);
                            if (bus.done) n_done++;
                        end
                        fin = 1'b1;
                    end else begin
                        n_rec++;
                        if (exp_vec == 127) hs_cyc = cyc + 1;
                        exp_vec++;
                    end
                end
            end
            if (!fin) begin
                bus.start = hold_start || (exp_vec == glitch_vec);
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (hs_cyc >= 0 && cyc > hs_cyc + 4) fin = 1'b1;
                if (cyc > 2000) begin
                    check_val("sweep_timeout", 1, 0);
                    fin = 1'b1;
                end
            end
        end
        bus.start = 1'b0;
        if (exp_hs >= 0) check_val("last_hs_cyc", hs_cyc, exp_hs);
        check_val("n_rec", n_rec, exp_rec);
        check_val("n_done", n_done, exp_done);
        check_val("drst_cycles", n_drst, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.rec_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_outs", {bus.busy, bus.done, bus.dut_rst, bus.dut_in, bus.rec_valid,
                                 bus.rec_vec, bus.rec_out, bus.rec_last}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_no_start", {bus.busy, bus.dut_rst}, 0);

        // Full sweep; a start pulse mid-sweep must be ignored.
        sweep(-1, -1, 60, 1'b0, 258, 128, 1);
        // Sink stalls five cycles on vector 10.
        sweep(10, -1, -1, 1'b0, 263, 128, 1);
        // Abort on the handshake edge of vector 40, then a clean restart.
        sweep(-1, 40, -1, 1'b0, -1, 40, 0);
        sweep(-1, -1, -1, 1'b0, 258, 128, 1);

        // Asynchronous reset while settling vector 6.
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (!(bus.rec_valid && bus.rec_vec == 7'd5) && cnt < 100) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
        check_val("wait_vec5", cnt < 100, 1);
        @(posedge clk);
        @(negedge clk);
        check_val("settle_state", {bus.busy, bus.rec_valid, bus.dut_in}, {1'b1, 1'b0, 7'd6});
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst", {bus.busy, bus.done, bus.dut_rst, bus.dut_in, bus.rec_valid,
                                bus.rec_vec, bus.rec_out, bus.rec_last}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_val("idle_after_rst", {bus.busy, bus.dut_rst}, 0);

        // start held through FIN re-launches one cycle after done.
        sweep(-1, -1, -1, 1'b1, 258, 128, 1);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("final_abort", bus.busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
